// File: rtl/mux2_sel_arbiter_pkg.sv
// Shared definitions for the 2:1 mux select arbiter: grant states and default sizing.
package mux2_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_t;

    localparam int HOLD_CYC_DEF = 4;
    localparam int CNT_W_DEF    = 3;

endpackage

// File: rtl/mux2_sel_arbiter_if.sv
// Request/grant bundle between the two requesters and the mux select arbiter.
interface mux2_sel_arbiter_if;

    logic req0;
    logic req1;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic busy;
    logic sw_pulse;

    modport master (
        output req0, req1,
        input  sel, gnt0, gnt1, busy, sw_pulse
    );

    modport slave (
        input  req0, req1,
        output sel, gnt0, gnt1, busy, sw_pulse
    );

endinterface

// File: rtl/mux2_hold_counter.sv
// Saturating grant-length counter; tc flags that the holder has used its full slot.
module mux2_hold_counter
    import mux2_sel_arbiter_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYC - 1);

    // Clear wins over enable so a fresh grant always starts its slot at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_MAX);

endmodule

// File: rtl/mux2_sel_arbiter.sv
// Registered round-robin arbiter driving the select line of the downstream 2:1 mux.
module mux2_sel_arbiter
    import mux2_sel_arbiter_pkg::*;
#(
    parameter int HOLD_CYC = HOLD_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mux2_sel_arbiter_if.slave    bus
);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             sel_q;
    logic             sel_nxt;
    logic             last;
    logic             last_nxt;
    logic             sw_pulse_q;
    logic             enter_grant;
    logic             stay_grant;
    logic             tc;
    logic [CNT_W-1:0] cnt;

    mux2_hold_counter #(
        .HOLD_CYC (HOLD_CYC),
        .CNT_W    (CNT_W)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clear  (enter_grant),
        .enable (stay_grant),
        .cnt    (cnt),
        .tc     (tc)
    );

    // last remembers which side was granted most recently; it breaks ties out of IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_nxt = last ? ST_GNT0 : ST_GNT1;
                end else if (bus.req0) begin
                    state_nxt = ST_GNT0;
                end else if (bus.req1) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!bus.req0 && bus.req1) begin
                    state_nxt = ST_GNT1;
                end else if (!bus.req0) begin
                    state_nxt = ST_IDLE;
                end else if (bus.req1 && tc) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT1: begin
                if (!bus.req1 && bus.req0) begin
                    state_nxt = ST_GNT0;
                end else if (!bus.req1) begin
                    state_nxt = ST_IDLE;
                end else if (bus.req0 && tc) begin
                    state_nxt = ST_GNT0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        enter_grant = (state_nxt != state) && (state_nxt != ST_IDLE);
        stay_grant  = (state_nxt == state) && (state != ST_IDLE);

        sel_nxt  = sel_q;
        last_nxt = last;
        if (enter_grant) begin
            sel_nxt  = (state_nxt == ST_GNT1);
            last_nxt = (state_nxt == ST_GNT1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sel_q      <= 1'b0;
            last       <= 1'b1;
            sw_pulse_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel_q      <= sel_nxt;
            last       <= last_nxt;
            sw_pulse_q <= (sel_nxt != sel_q);
        end
    end

    assign bus.sel      = sel_q;
    assign bus.gnt0     = (state == ST_GNT0);
    assign bus.gnt1     = (state == ST_GNT1);
    assign bus.busy     = (state == ST_GNT0) || (state == ST_GNT1);
    assign bus.sw_pulse = sw_pulse_q;

endmodule

// File: tb/tb_mux2_sel_arbiter.sv
// Directed bench for mux2_sel_arbiter with HOLD_CYC=4; outputs packed as {gnt0,gnt1,sel,busy,sw_pulse}.
module tb_mux2_sel_arbiter;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic inv_on;

    mux2_sel_arbiter_if bus ();

    mux2_sel_arbiter #(
        .HOLD_CYC (4),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle just past it.
    task automatic applyStimulus(input logic r0, input logic r1, input logic rs);
        bus.req0 = r0;
        bus.req1 = r1;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic expectOut(input string tag, input logic [4:0] exp_v);
        checkOutput(tag, {3'b000, bus.gnt0, bus.gnt1, bus.sel, bus.busy, bus.sw_pulse}, {3'b000, exp_v});
    endtask

    always @(negedge clk) begin
        if (inv_on) begin
            checkOutput("inv_excl", {7'd0, bus.gnt0 & bus.gnt1}, 8'd0);
            checkOutput("inv_sel1", {7'd0, bus.gnt1 & ~bus.sel}, 8'd0);
            checkOutput("inv_sel0", {7'd0, bus.gnt0 & bus.sel}, 8'd0);
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        inv_on   = 1'b0;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // Reset, then a lone request on side 0.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        inv_on = 1'b1;
        expectOut("reset", 5'b00000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("single_req0", 5'b10010);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectOut("single_idle", 5'b00000);

        // Simultaneous first request, then alternation every 4 cycles.
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectOut("reset2", 5'b00000);
        for (int i = 1; i <= 12; i++) begin
            logic side;
            logic pulse;
            side  = ((i - 1) / 4) % 2 == 1;
            pulse = (i > 1) && ((i - 1) % 4 == 0);
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectOut($sformatf("alt_%0d", i), {~side, side, side, 1'b1, pulse});
        end

        // Voluntary handover at cycle 2 of a grant.
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectOut("hand_g0", 5'b10010);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("hand_c2", 5'b10010);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectOut("hand_g1", 5'b01111);

        // Release to idle keeps sel; re-grant of the same side gives no pulse.
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectOut("idle_sel1", 5'b00100);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectOut("regrant_g1", 5'b01110);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            expectOut($sformatf("hold_g1_%0d", i), 5'b01110);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("preempt_g0", 5'b10011);

        // Saturated lone holder is pre-empted one edge after contention appears.
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            expectOut($sformatf("lone_%0d", i), 5'b10010);
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("sat_preempt", 5'b01111);

        // Reset in the middle of a GNT1 grant.
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("mid_g1_c2", 5'b01110);
        applyStimulus(1'b1, 1'b1, 1'b1);
        expectOut("mid_reset", 5'b00000);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectOut("post_reset_g0", 5'b10010);

        inv_on = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_sel_arbiter.md
Name: mux2_sel_arbiter

Overview:
- Registered round-robin arbiter that drives the select line of the 2:1 mux stage and sits directly upstream of it.
- Two requesters compete for the mux path.
- The arbiter grants one at a time, holds `sel` stable for the whole grant, and pre-empts a long holder once the other side is waiting.
- `sel` connects straight to the mux `sel` input. `sel=0` routes `in0`; `sel=1` routes `in1`.

Parameters:
- HOLD_CYC, default 4: maximum grant length in cycles while the other requester is waiting. Legal range 2..2**CNT_W.
- CNT_W, default 3: width of the hold counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the mux path (`in0`).
- req1  input  1  requester 1 wants the mux path (`in1`).
- sel  output  1  mux select, registered.
- gnt0  output  1  requester 0 owns the path, registered.
- gnt1  output  1  requester 1 owns the path, registered.
- busy  output  1  `gnt0 | gnt1`.
- sw_pulse  output  1  one-cycle pulse in the cycle `sel` takes a new value.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, sel=0, gnt0=gnt1=0, sw_pulse=0, hold count=0, last=1, so requester 0 wins the first contest. Reset overrides everything, including mid-grant; the grant drops in the cycle after the reset edge.
- States: IDLE, GNT0, GNT1. Encoding is one-hot or binary, implementer's choice. gnt0=1 iff GNT0; gnt1=1 iff GNT1.
- Latency: one clock from a request being sampled high to the corresponding gnt and sel being updated.
- IDLE transitions:
  - no request: stay IDLE; sel holds its last value.
  - one request: go to that requester's grant state.
  - both requests: grant the requester that is not `last`.
- GNTx transitions (y is the other requester):
  - reqx=0 and reqy=1: go directly to GNTy. No idle gap.
  - reqx=0 and reqy=0: go to IDLE.
  - reqx=1, reqy=1 and cnt==HOLD_CYC-1: pre-empt, go to GNTy.
  - otherwise: stay in GNTx.
- Hold counter:
  - cleared on entry to any grant state.
  - increments each cycle in the same grant and saturates at HOLD_CYC-1.
  - A lone holder that later sees contention with cnt saturated is pre-empted at the next edge.
- `last` updates to x on entry to GNTx.
- sel updates on entry to GNT0 (0) or GNT1 (1). It is unchanged in IDLE and while a grant is held.
- sw_pulse=1 for exactly the cycle after the edge where sel changed value. Re-granting the same side after IDLE gives no pulse.
- Requests are level-sensitive; requesters keep req high until done. A request dropped and re-raised in the same cycle is not visible.
- Invariants the bench must assert: gnt0 & gnt1 never both 1; sel==1 whenever gnt1; sel==0 whenever gnt0.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_GNT0, ST_GNT1) and the default HOLD_CYC.
- One natural sub-module: mux2_hold_counter (clear, enable, saturating at HOLD_CYC-1, terminal-count flag).
- Next-state/grant logic stays in the top module.

Test Plan (HOLD_CYC=4):
1. Reset then single request: rst=1 for 2 cycles, release, req0=1 → gnt0=1, sel=0 one cycle later; busy=1; sw_pulse=0.
2. Simultaneous first request: after reset, req0=req1=1 in the same cycle → GNT0 first (last=1). Both held high → GNT1 after 4 cycles of gnt0; sw_pulse=1 for one cycle; sel=1. Alternation every 4 cycles thereafter.
3. Voluntary handover: in GNT0, req1=1; drop req0 at cycle 2 of the grant → next edge gnt0=0, gnt1=1, sel=1. No IDLE cycle and no pre-emption.
4. Release to idle: in GNT1, drop req1 with req0=0 → IDLE; gnt1=0; sel stays 1. Then req1=1 → GNT1 with sw_pulse=0. Then req0=1 → GNT0 after 4 cycles.
5. Saturated lone holder: req0 alone for 10 cycles, then req1=1 → gnt1=1 exactly one edge later.
6. Reset mid-operation: rst=1 during GNT1 at cycle 2 → next edge sel=0, gnt1=0, busy=0. After release with req0=req1=1 → GNT0 wins.
